can_err_frame_tx: RTL and testbench

Generates CAN error frames on the bus once the error control unit has flagged an error, and produces the counter-update codes for that unit. It drives the active or passive error flag selected by the current error state, monitors flag superposition, and sends the error delimiter and intermission. It sits between the error control unit and the bit-level TX mux, and owns `tx_out` while an error frame is in progress.

---
 rtl/can_err_frame_tx.sv | 273 +++++++++++++++++++++++++++
 tb/tb_can_err_frame_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_err_frame_tx.sv
// CAN error frame transmitter: drives the active/passive error flag, watches flag
// superposition, then sends delimiter and intermission. Optional overload frames via CAN_ERR_OVERLOAD_EN.
module can_err_frame_tx #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int INTER_LEN = 3
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       tx_strobe,
    input  logic       bitstrobe,
    input  logic       curr_sample,
    input  logic       start_err_tx,
    input  logic [1:0] error_state,
    input  logic       is_transmitter,
`ifdef CAN_ERR_OVERLOAD_EN
    input  logic       start_ovld,
`endif
    output logic       tx_out,
    output logic       err_busy,
    output logic       err_done,
    output logic [1:0] rx_code,
    output logic [1:0] tx_code
);

    localparam int FW = $clog2(FLAG_LEN + 1);
    localparam int DW = $clog2(DELIM_LEN + 1);
    localparam int IW = $clog2(INTER_LEN + 1);

    localparam logic [FW-1:0] FLAG_MAX  = FW'(FLAG_LEN);
    localparam logic [FW-1:0] F_ZERO    = FW'(0);
    localparam logic [FW-1:0] F_ONE     = FW'(1);
    localparam logic [DW-1:0] DELIM_MAX = DW'(DELIM_LEN);
    localparam logic [DW-1:0] D_ZERO    = DW'(0);
    localparam logic [DW-1:0] D_ONE     = DW'(1);
    localparam logic [IW-1:0] INTER_MAX = IW'(INTER_LEN);
    localparam logic [IW-1:0] I_ZERO    = IW'(0);
    localparam logic [IW-1:0] I_ONE     = IW'(1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FLAG     = 3'd1;
    localparam logic [2:0] ST_WAIT_REC = 3'd2;
    localparam logic [2:0] ST_DELIM    = 3'd3;
    localparam logic [2:0] ST_INTER    = 3'd4;

    logic [2:0]    state_r,    state_n;
    logic          passive_r,  passive_n;
    logic          is_tx_r,    is_tx_n;
    logic          ovld_r,     ovld_n;
    logic [FW-1:0] bit_cnt_r,  bit_cnt_n;
    logic [FW-1:0] eq_cnt_r,   eq_cnt_n;
    logic          last_smp_r, last_smp_n;
    logic [3:0]    dom_cnt_r,  dom_cnt_n;
    logic          first_r,    first_n;
    logic [DW-1:0] del_cnt_r,  del_cnt_n;
    logic [IW-1:0] int_cnt_r,  int_cnt_n;
    logic          tx_out_r,   tx_out_n;
    logic          busy_r,     busy_n;
    logic          done_r,     done_n;
    logic [1:0]    rx_code_r,  rx_code_n;
    logic [1:0]    tx_code_r,  tx_code_n;

    logic          start_err_s;
    logic          start_ovld_s;
    logic          enter_s;
    logic [3:0]    dom_sum_s;
    logic          hit8_s;

    assign start_err_s = start_err_tx & ~error_state[1];
`ifdef CAN_ERR_OVERLOAD_EN
    assign start_ovld_s = start_ovld & ~error_state[1];
`else
    assign start_ovld_s = 1'b0;
`endif

    // Next-state: sample processing at bitstrobe first, then drive at tx_strobe, bus-off last
    always_comb begin
        state_n    = state_r;
        passive_n  = passive_r;
        is_tx_n    = is_tx_r;
        ovld_n     = ovld_r;
        bit_cnt_n  = bit_cnt_r;
        eq_cnt_n   = eq_cnt_r;
        last_smp_n = last_smp_r;
        dom_cnt_n  = dom_cnt_r;
        first_n    = first_r;
        del_cnt_n  = del_cnt_r;
        int_cnt_n  = int_cnt_r;
        tx_out_n   = tx_out_r;
        rx_code_n  = rx_code_r;
        tx_code_n  = tx_code_r;
        done_n     = 1'b0;
        enter_s    = 1'b0;
        dom_sum_s  = dom_cnt_r + 4'd1;
        hit8_s     = (dom_sum_s == 4'd8);

        if (bitstrobe) begin
            rx_code_n = 2'b00;
            tx_code_n = 2'b00;
            case (state_r)
                ST_IDLE, ST_INTER: begin
                    if (start_err_s) begin
                        enter_s   = 1'b1;
                        state_n   = ST_FLAG;
                        passive_n = error_state[0];
                        is_tx_n   = is_transmitter;
                        ovld_n    = 1'b0;
                    end else if (start_ovld_s) begin
                        enter_s   = 1'b1;
                        state_n   = ST_FLAG;
                        passive_n = 1'b0;
                        is_tx_n   = is_transmitter;
                        ovld_n    = 1'b1;
                    end else if (state_r == ST_INTER) begin
                        int_cnt_n = int_cnt_r + I_ONE;
                        if (int_cnt_n == INTER_MAX) begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_INTER;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_FLAG: begin
                    if (passive_r) begin
                        // Passive flag ends after FLAG_LEN equal samples, whatever their value
                        if (eq_cnt_r == F_ZERO || curr_sample != last_smp_r) begin
                            eq_cnt_n = F_ONE;
                        end else if (eq_cnt_r < FLAG_MAX) begin
                            eq_cnt_n = eq_cnt_r + F_ONE;
                        end else begin
                            eq_cnt_n = eq_cnt_r;
                        end
                        last_smp_n = curr_sample;
                    end else begin
                        eq_cnt_n = eq_cnt_r;
                    end
                    if ((passive_r && eq_cnt_n == FLAG_MAX) || (!passive_r && bit_cnt_r == FLAG_MAX)) begin
                        state_n   = ST_WAIT_REC;
                        first_n   = 1'b1;
                        dom_cnt_n = 4'd0;
                    end else begin
                        state_n = ST_FLAG;
                    end
                end
                ST_WAIT_REC: begin
                    first_n = 1'b0;
                    if (curr_sample) begin
                        del_cnt_n = D_ONE;
                        int_cnt_n = I_ZERO;
                        state_n   = (DELIM_LEN <= 1) ? ST_INTER : ST_DELIM;
                    end else begin
                        dom_cnt_n = hit8_s ? 4'd0 : dom_sum_s;
                        if (!ovld_r && !is_tx_r && (first_r || hit8_s)) begin
                            rx_code_n = 2'b10;
                        end else begin
                            rx_code_n = 2'b00;
                        end
                        if (!ovld_r && is_tx_r && hit8_s) begin
                            tx_code_n = 2'b10;
                        end else begin
                            tx_code_n = 2'b00;
                        end
                    end
                end
                ST_DELIM: begin
                    if (curr_sample) begin
                        del_cnt_n = del_cnt_r + D_ONE;
                        if (del_cnt_n == DELIM_MAX) begin
                            state_n   = ST_INTER;
                            int_cnt_n = I_ZERO;
                        end else begin
                            state_n = ST_DELIM;
                        end
                    end else begin
                        enter_s   = 1'b1;
                        state_n   = ST_FLAG;
                        passive_n = ovld_r ? 1'b0 : error_state[0];
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else begin
            rx_code_n = rx_code_r;
            tx_code_n = tx_code_r;
        end

        if (enter_s) begin
            bit_cnt_n  = F_ZERO;
            eq_cnt_n   = F_ZERO;
            last_smp_n = 1'b1;
            dom_cnt_n  = 4'd0;
            first_n    = 1'b0;
            del_cnt_n  = D_ZERO;
            int_cnt_n  = I_ZERO;
        end else begin
            first_n = first_n;
        end

        if (tx_strobe) begin
            if (state_n == ST_FLAG && !passive_n && bit_cnt_n < FLAG_MAX) begin
                tx_out_n  = 1'b0;
                bit_cnt_n = bit_cnt_n + F_ONE;
            end else begin
                tx_out_n = 1'b1;
            end
        end else begin
            tx_out_n = tx_out_r;
        end

        if (error_state[1]) begin
            state_n   = ST_IDLE;
            tx_out_n  = 1'b1;
            done_n    = 1'b0;
            rx_code_n = 2'b00;
            tx_code_n = 2'b00;
        end else begin
            done_n = done_n;
        end

        busy_n = (state_n != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r    <= ST_IDLE;
            passive_r  <= 1'b0;
            is_tx_r    <= 1'b0;
            ovld_r     <= 1'b0;
            bit_cnt_r  <= F_ZERO;
            eq_cnt_r   <= F_ZERO;
            last_smp_r <= 1'b1;
            dom_cnt_r  <= 4'd0;
            first_r    <= 1'b0;
            del_cnt_r  <= D_ZERO;
            int_cnt_r  <= I_ZERO;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rx_code_r  <= 2'b00;
            tx_code_r  <= 2'b00;
        end else begin
            state_r    <= state_n;
            passive_r  <= passive_n;
            is_tx_r    <= is_tx_n;
            ovld_r     <= ovld_n;
            bit_cnt_r  <= bit_cnt_n;
            eq_cnt_r   <= eq_cnt_n;
            last_smp_r <= last_smp_n;
            dom_cnt_r  <= dom_cnt_n;
            first_r    <= first_n;
            del_cnt_r  <= del_cnt_n;
            int_cnt_r  <= int_cnt_n;
            tx_out_r   <= tx_out_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            rx_code_r  <= rx_code_n;
            tx_code_r  <= tx_code_n;
        end
    end

    assign tx_out   = tx_out_r;
    assign err_busy = busy_r;
    assign err_done = done_r;
    assign rx_code  = rx_code_r;
    assign tx_code  = tx_code_r;

endmodule

// File: tb/tb_can_err_frame_tx.sv
// Bench for can_err_frame_tx: bit-time stimulus with a wired-AND bus against a frame-level reference model.
module tb_can_err_frame_tx;

    localparam int FLAG_LEN  = 6;
    localparam int DELIM_LEN = 8;
    localparam int INTER_LEN = 3;

    localparam int P_IDLE  = 0;
    localparam int P_FLAG  = 1;
    localparam int P_WREC  = 2;
    localparam int P_DELIM = 3;
    localparam int P_INTER = 4;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       tx_strobe = 1'b0;
    logic       bitstrobe = 1'b0;
    logic       curr_sample = 1'b1;
    logic       start_err_tx = 1'b0;
    logic [1:0] error_state = 2'b00;
    logic       is_transmitter = 1'b0;
`ifdef CAN_ERR_OVERLOAD_EN
    logic       start_ovld = 1'b0;
`endif
    logic       tx_out;
    logic       err_busy;
    logic       err_done;
    logic [1:0] rx_code;
    logic [1:0] tx_code;

    can_err_frame_tx dut (
        .clk(clk), .nRST(nRST), .tx_strobe(tx_strobe), .bitstrobe(bitstrobe),
        .curr_sample(curr_sample), .start_err_tx(start_err_tx), .error_state(error_state),
        .is_transmitter(is_transmitter),
`ifdef CAN_ERR_OVERLOAD_EN
        .start_ovld(start_ovld),
`endif
        .tx_out(tx_out), .err_busy(err_busy), .err_done(err_done),
        .rx_code(rx_code), .tx_code(tx_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: phase plus plain counts since flag start / flag end
    int m_ph;
    int m_fb;
    bit m_pas;
    bit m_istx;
    bit pq[$];
    int m_run;
    int m_del;
    int m_ic;
    bit m_rx, m_tx, m_done;
    bit flag_pat[$];

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_ph = P_IDLE; m_fb = 0; m_pas = 1'b0; m_istx = 1'b0; pq.delete();
        m_run = 0; m_del = 0; m_ic = 0; m_rx = 1'b0; m_tx = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void m_enter();
        m_ph = P_FLAG; m_pas = error_state[0]; m_istx = is_transmitter;
        m_fb = 0; pq.delete(); m_run = 0; m_del = 0; m_ic = 0;
    endfunction

    function automatic bit m_drive();
        if (m_ph == P_FLAG && !m_pas && m_fb < FLAG_LEN) begin
            m_fb++;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_sample(input bit s, input bit start);
        bit all_eq;
        m_rx = 1'b0; m_tx = 1'b0; m_done = 1'b0;
        case (m_ph)
            P_IDLE: if (start && !error_state[1]) m_enter();
            P_FLAG: begin
                if (m_pas) begin
                    pq.push_back(s);
                    if (pq.size() >= FLAG_LEN) begin
                        all_eq = 1'b1;
                        for (int i = pq.size() - FLAG_LEN; i < pq.size(); i++)
                            if (pq[i] != s) all_eq = 1'b0;
                        if (all_eq) m_ph = P_WREC;
                    end
                end else if (m_fb >= FLAG_LEN) begin
                    m_ph = P_WREC;
                end
            end
            P_WREC: begin
                if (s) begin
                    m_del = 1; m_ph = P_DELIM;
                end else begin
                    m_run++;
                    m_rx = !m_istx && (m_run == 1 || m_run % 8 == 0);
                    m_tx = m_istx && (m_run % 8 == 0);
                end
            end
            P_DELIM: begin
                if (s) begin
                    m_del++;
                    if (m_del == DELIM_LEN) begin m_ph = P_INTER; m_ic = 0; end
                end else begin
                    m_enter();
                end
            end
            P_INTER: begin
                if (start && !error_state[1]) m_enter();
                else begin
                    m_ic++;
                    if (m_ic == INTER_LEN) begin m_ph = P_IDLE; m_done = 1'b1; end
                end
            end
            default: m_ph = P_IDLE;
        endcase
    endfunction

    // One bit time: drive point, then sample point with other nodes' drive ext on a wired-AND bus
    task automatic do_bit(input bit ext, input bit start);
        bit d;
        @(negedge clk); tx_strobe = 1'b1;
        @(negedge clk); tx_strobe = 1'b0;
        d = m_drive();
        chk("tx_drive", tx_out, d);
        @(negedge clk);
        @(negedge clk); bitstrobe = 1'b1; curr_sample = d & ext; start_err_tx = start;
        @(negedge clk); bitstrobe = 1'b0; start_err_tx = 1'b0;
        m_sample(d & ext, start);
        chk("tx_hold", tx_out, d);
        chk("rx_code", rx_code, {m_rx, 1'b0});
        chk("tx_code", tx_code, {m_tx, 1'b0});
        chk("busy", err_busy, m_ph != P_IDLE);
        chk("done", err_done, m_done);
        @(negedge clk);
        chk("done_pulse", err_done, 1'b0);
        chk("rx_hold", rx_code, {m_rx, 1'b0});
    endtask

    task automatic run_frame(input int ndom, input int hit_at, input bit inter_restart);
        int guard;
        int nd;
        int ha;
        bit ext, st, restarted;
        nd = ndom; ha = hit_at; restarted = 1'b0; guard = 0;
        do_bit(1'b1, 1'b1);
        while (m_ph != P_IDLE && guard < 400) begin
            ext = 1'b1; st = 1'b0;
            case (m_ph)
                P_FLAG: begin
                    if (m_pas) begin
                        if (flag_pat.size() > 0) ext = flag_pat.pop_front();
                        else ext = ($urandom_range(0, 5) == 0);
                    end
                end
                P_WREC: if (nd > 0) begin ext = 1'b0; nd--; end
                P_DELIM: if (ha != 0 && m_del == ha) begin ext = 1'b0; ha = 0; end
                P_INTER: if (inter_restart && !restarted && m_ic == 1) begin st = 1'b1; restarted = 1'b1; end
                default: ext = 1'b1;
            endcase
            do_bit(ext, st);
            guard++;
        end
        chk("frame_bound", guard < 400, 1'b1);
        flag_pat.delete();
    endtask

    initial begin
        int guard;
        bit d;
        m_reset();
        #12;
        chk("rst_tx_out", tx_out, 1'b1);
        chk("rst_busy", err_busy, 1'b0);
        chk("rst_done", err_done, 1'b0);
        chk("rst_rx_code", rx_code, 2'b00);
        chk("rst_tx_code", tx_code, 2'b00);
        @(negedge clk); nRST = 1'b1;
        do_bit(1'b1, 1'b0);
        do_bit(1'b1, 1'b0);

        // Active error, receiver, clean bus
        error_state = 2'b00; is_transmitter = 1'b0;
        run_frame(0, 0, 1'b0);
        // Superposition: one dominant bit (receiver), sixteen (transmitter and receiver)
        run_frame(1, 0, 1'b0);
        is_transmitter = 1'b1;
        run_frame(16, 0, 1'b0);
        is_transmitter = 1'b0;
        run_frame(16, 0, 1'b0);
        // Passive flag with samples 1,0,0,0,0,0,0
        error_state = 2'b01;
        flag_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_frame(1, 0, 1'b0);
        // Dominant at delimiter bit 4, then restart in intermission
        error_state = 2'b00;
        run_frame(0, 3, 1'b0);
        run_frame(0, 0, 1'b1);

        // Bus-off at flag bit 3
        do_bit(1'b1, 1'b1);
        do_bit(1'b1, 1'b0);
        do_bit(1'b1, 1'b0);
        @(negedge clk); tx_strobe = 1'b1;
        @(negedge clk); tx_strobe = 1'b0;
        d = m_drive();
        chk("bo_flag_bit3", tx_out, d);
        error_state = 2'b10;
        @(negedge clk);
        chk("bo_tx_out", tx_out, 1'b1);
        chk("bo_busy", err_busy, 1'b0);
        chk("bo_done", err_done, 1'b0);
        m_reset();
        error_state = 2'b00;
        for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b0);

        // Reset pulse in the middle of the delimiter
        do_bit(1'b1, 1'b1);
        guard = 0;
        while (m_ph != P_DELIM && guard < 40) begin do_bit(1'b1, 1'b0); guard++; end
        chk("reach_delim", guard < 40, 1'b1);
        do_bit(1'b1, 1'b0);
        @(negedge clk); #2 nRST = 1'b0;
        #1;
        chk("ar_tx_out", tx_out, 1'b1);
        chk("ar_busy", err_busy, 1'b0);
        chk("ar_done", err_done, 1'b0);
        chk("ar_rx_code", rx_code, 2'b00);
        chk("ar_tx_code", tx_code, 2'b00);
        @(negedge clk); nRST = 1'b1;
        m_reset();
        for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b0);
        run_frame(0, 0, 1'b0);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            error_state = 2'($urandom_range(0, 1));
            is_transmitter = 1'($urandom_range(0, 1));
            run_frame($urandom_range(0, 20),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, DELIM_LEN - 1) : 0,
                      ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) do_bit(1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
